uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
Sequences a multi-byte UART transmission once the latched start pulse and the configuration (data byte, byte count, inter-byte delay) are available.
- Issues bytes to the UART TX core over a valid/ready handshake.
- Inserts a programmable gap between bytes, measured in slow delay ticks.
- Reports progress and completion to the status/seven-segment logic.
- Payload byte k equals data_in + k, modulo 2^DATA_W.

Parameters:
DATA_W, 8, payload byte width
CNT_W, 15, byte count / progress counter width
DLY_W, 8, inter-byte delay width (in tick_en units)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled only in IDLE
data_in  in  DATA_W  first payload byte, latched on accepted start
byte_count  in  CNT_W  number of bytes to send, latched on accepted start
delay_ticks  in  DLY_W  gap length in tick_en pulses, latched on accepted start
tick_en  in  1  single-cycle delay time base
tx_valid  out  1  byte available to UART core
tx_data  out  DATA_W  byte to UART core
tx_ready  in  1  UART core can accept a byte
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
bytes_sent  out  CNT_W  bytes accepted by the core in the current/last sequence

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; latched config and counters cleared.
- Handshake: a transfer occurs on a clk edge where tx_valid=1 and tx_ready=1.
  - tx_data is stable while tx_valid=1.
  - tx_valid never drops without a transfer, except on abort (Optional Feature).
- State IDLE:
  - On start=1: latch data_in, byte_count, delay_ticks.
  - bytes_sent<=0.
  - If latched count is 0: stay IDLE, pulse done next cycle, busy stays 0.
  - If count is nonzero: go to SEND; busy=1 and tx_valid=1 with tx_data=data_in in the next cycle (1-cycle latency).
- State SEND:
  - Hold tx_valid until transfer.
  - On transfer: bytes_sent+1 and tx_data+1 (wraps 0xFF->0x00), registered.
  - If the transferred byte was the last one (bytes_sent+1 == count): go to IDLE; done=1 for one cycle and busy=0 in the next cycle; tx_valid=0.
  - Else if delay=0: tx_valid stays high; next byte presented in the next cycle (back-to-back).
  - Else: tx_valid=0; go to GAP with gap counter = delay.
- State GAP:
  - Decrement the gap counter on each tick_en.
  - On the tick_en that takes the counter 1->0: go to SEND; tx_valid=1 in the next cycle.
  - Cycles without tick_en leave the counter unchanged.
- start while busy=1 is ignored; latched config is unaffected.
- Input changes after start is accepted have no effect.
- bytes_sent holds its final value in IDLE until the next accepted start.
- Max count 2^CNT_W-1; no overflow possible since the counter stops at count.
- A reset_n assertion mid-sequence aborts immediately; no done pulse is produced.

Optional Feature:
Macro UART_TX_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, one-cycle pulse, reset 0).
  - abort=1 in SEND or GAP: next state IDLE, tx_valid=0, busy=0, aborted=1 in the next cycle, done not pulsed.
  - If abort coincides with a transfer, the byte is counted in bytes_sent, then the sequence aborts.
  - abort in IDLE has no effect.
- Not defined: no abort/aborted ports; sequences always run to completion or reset.

Test Plan:
- Reset values: reset_n low mid-sequence with tx_valid=1 -> all outputs 0 immediately (async); after release, state IDLE, no done.
- Back-to-back: data_in=0x41, byte_count=3, delay=0, tx_ready=1 constant -> tx_data 0x41,0x42,0x43 on 3 consecutive cycles; done 1 cycle after the 3rd; bytes_sent=3.
- Gap and backpressure: data_in=0xFE, count=3, delay=2, tick_en every 4 cycles, tx_ready low 5 cycles per byte -> bytes 0xFE,0xFF,0x00 (wrap); tx_valid low for exactly 2 tick_en pulses between bytes; tx_data stable while stalled.
- Zero count: start with byte_count=0 -> tx_valid never high, busy stays 0, done pulses once, bytes_sent=0.
- Start while busy: second start with data_in=0x99 during a 10-byte run -> ignored; payload continues from the original data; exactly 10 transfers, one done.
- Abort (macro defined): count=256, delay=0, abort on the same cycle as the 5th transfer -> bytes_sent=5, aborted pulse, no done, tx_valid low next cycle.

Source files
------------

// File: rtl/uart_tx_sequencer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer_if
//
// Purpose:
//   Valid/ready byte channel between the TX sequencer and the UART TX core.
//   A byte moves on a clk edge where tx_valid and tx_ready are both high.
//
// Signals:
//   tx_valid  sequencer -> core   byte available
//   tx_data   sequencer -> core   byte value, held stable while tx_valid=1
//   tx_ready  core -> sequencer   core can accept a byte
//
// Modports:
//   master  the byte source (sequencer)
//   slave   the byte sink (UART TX core)
// -----------------------------------------------------------------------------
interface uart_tx_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// uart_tx_sequencer
//
// Purpose:
//   Sends a multi-byte UART payload after a start request. Byte k of the
//   payload is data_in + k (mod 2^DATA_W). Between bytes, a programmable gap
//   is inserted, measured in tick_en pulses. Progress and completion are
//   reported to the status logic.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   start        start request, sampled only while idle
//   data_in      first payload byte, latched on accepted start
//   byte_count   number of bytes to send, latched on accepted start
//   delay_ticks  inter-byte gap in tick_en pulses, latched on accepted start
//   tick_en      single-cycle time base for the gap
//   tx           valid/ready byte channel to the UART core (master side)
//   busy         sequence in progress
//   done         one-cycle pulse when a sequence completes
//   bytes_sent   bytes accepted by the core in the current/last sequence
//
// Optional feature (macro UART_TX_SEQ_ABORT_EN):
//   abort        input; ends a running sequence at the next edge
//   aborted      output; one-cycle pulse after an abort, done is not pulsed
// -----------------------------------------------------------------------------
module uart_tx_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 15,
    parameter int DLY_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [CNT_W-1:0]    byte_count,
    input  logic [DLY_W-1:0]    delay_ticks,
    input  logic                tick_en,
    uart_tx_sequencer_if.master tx,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    bytes_sent
`ifdef UART_TX_SEQ_ABORT_EN
    ,
    input  logic                abort,
    output logic                aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [DLY_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              done_q, done_d;
    logic              xfer;
    logic [CNT_W-1:0]  sent_inc;
`ifdef UART_TX_SEQ_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    // tx_valid is exactly "in SEND", so a byte moves whenever the core is ready there
    assign xfer     = (state_q == SEND) && tx.tx_ready;
    assign sent_inc = sent_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            count_q   <= '0;
            delay_q   <= '0;
            gap_q     <= '0;
            sent_q    <= '0;
            done_q    <= 1'b0;
`ifdef UART_TX_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            count_q   <= count_d;
            delay_q   <= delay_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            done_q    <= done_d;
`ifdef UART_TX_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        delay_d   = delay_q;
        gap_d     = gap_q;
        sent_d    = sent_q;
        done_d    = 1'b0;
`ifdef UART_TX_SEQ_ABORT_EN
        aborted_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    count_d = byte_count;
                    delay_d = delay_ticks;
                    sent_d  = '0;
                    // An empty sequence completes at once without ever going busy
                    if (byte_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            SEND: begin
                if (xfer) begin
                    sent_d = sent_inc;
                    data_d = data_q + 1'b1;
                    if (sent_inc == count_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (delay_q != '0) begin
                        state_d = GAP;
                        gap_d   = delay_q;
                    end
                end
            end

            GAP: begin
                // gap_q is never 0 here because GAP is only entered with a nonzero delay
                if (tick_en) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == DLY_W'(1)) begin
                        state_d = SEND;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_TX_SEQ_ABORT_EN
        // Abort wins over completion; a coinciding transfer has already been counted above
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
`endif
    end

    assign tx.tx_valid = (state_q == SEND);
    assign tx.tx_data  = data_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign bytes_sent  = sent_q;
`ifdef UART_TX_SEQ_ABORT_EN
    assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sequencer
//
// Self-checking bench for uart_tx_sequencer. A negedge monitor logs every
// handshake, the tick_en pulses seen between bytes, done/aborted pulses and
// any tx_valid/tx_data instability; each sequence is then compared with the
// payload rule (byte k = data_in + k mod 256, gap = delay_ticks ticks).
// Abort checks are built when UART_TX_SEQ_ABORT_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 15;
    localparam int DLY_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [CNT_W-1:0]  byte_count = '0;
    logic [DLY_W-1:0]  delay_ticks = '0;
    logic              tick_en = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bytes_sent;
`ifdef UART_TX_SEQ_ABORT_EN
    logic              abort = 1'b0;
    logic              aborted;
`endif

    uart_tx_sequencer_if #(.DATA_W(DATA_W)) tx_if ();

    uart_tx_sequencer #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .DLY_W (DLY_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .data_in    (data_in),
        .byte_count (byte_count),
        .delay_ticks(delay_ticks),
        .tick_en    (tick_en),
        .tx         (tx_if),
        .busy       (busy),
        .done       (done),
        .bytes_sent (bytes_sent)
`ifdef UART_TX_SEQ_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment knobs: ready_mode 0=always ready, 1=random, 2=5-cycle stall per byte;
    // tick_period 0=random ticks, N>0=one tick every N cycles
    int ready_mode  = 0;
    int tick_period = 1;

    // Monitor log for the current sequence
    logic [DATA_W-1:0] xfer_log[$];
    int                gap_log[$];
    int                cycle = 0;
    int                done_cnt, aborted_cnt, stall_err, tick_cnt;
    int                last_xfer_cycle, first_done_cycle;
    bit                busy_seen, valid_seen, counting, prev_stall;
    logic [DATA_W-1:0] prev_data;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic resetStats();
        xfer_log.delete();
        gap_log.delete();
        done_cnt         = 0;
        aborted_cnt      = 0;
        stall_err        = 0;
        tick_cnt         = 0;
        last_xfer_cycle  = -1;
        first_done_cycle = -1;
        busy_seen        = 1'b0;
        valid_seen       = 1'b0;
        counting         = 1'b0;
        prev_stall       = 1'b0;
    endtask

    // Monitor: values seen at a negedge are the ones the next posedge acts on
    initial begin
        resetStats();
        forever begin
            @(negedge clk);
            cycle++;
            if (prev_stall && reset_n) begin
                if (!tx_if.tx_valid || (tx_if.tx_data !== prev_data)) stall_err++;
            end
            if (busy) busy_seen = 1'b1;
            if (tx_if.tx_valid) valid_seen = 1'b1;
            if (done) begin
                done_cnt++;
                if (first_done_cycle < 0) first_done_cycle = cycle;
            end
`ifdef UART_TX_SEQ_ABORT_EN
            if (aborted) aborted_cnt++;
`endif
            if (counting) begin
                if (!busy) begin
                    counting = 1'b0;
                end else if (tx_if.tx_valid) begin
                    gap_log.push_back(tick_cnt);
                    counting = 1'b0;
                end else if (tick_en) begin
                    tick_cnt++;
                end
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                xfer_log.push_back(tx_if.tx_data);
                last_xfer_cycle = cycle;
                counting        = 1'b1;
                tick_cnt        = 0;
                prev_stall      = 1'b0;
            end else begin
                prev_stall = tx_if.tx_valid;
                prev_data  = tx_if.tx_data;
            end
        end
    end

    // Environment driver for tick_en and tx_ready, updated 1 time unit after each edge
    initial begin
        int tick_phase = 0;
        int stall      = 0;
        tx_if.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_period > 0) tick_en = ((tick_phase % tick_period) == 0);
            else                 tick_en = ($urandom_range(0, 2) == 0);
            tick_phase++;
            case (ready_mode)
                0: tx_if.tx_ready = 1'b1;
                1: tx_if.tx_ready = $urandom_range(0, 1) != 0;
                default: begin
                    if (tx_if.tx_ready) begin
                        tx_if.tx_ready = 1'b0;
                        stall          = 0;
                    end else if (tx_if.tx_valid) begin
                        if (stall == 5) tx_if.tx_ready = 1'b1;
                        else            stall++;
                    end
                end
            endcase
        end
    end

    // Issue one start pulse, then scramble the config inputs to prove they were latched
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input int cnt, input int dly);
        resetStats();
        data_in     = d;
        byte_count  = cnt[CNT_W-1:0];
        delay_ticks = dly[DLY_W-1:0];
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        data_in     = DATA_W'($urandom);
        byte_count  = CNT_W'($urandom);
        delay_ticks = DLY_W'($urandom);
    endtask

    task automatic runSequence(input logic [DATA_W-1:0] d, input int cnt, input int dly,
                               input bit inject, input string name);
        bit finished = 1'b0;
        applyStimulus(d, cnt, dly);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (inject && i == 4) begin
                checkOutput({name, "_busy_at_restart"}, 32'(busy), 32'd1);
                start       = 1'b1;
                data_in     = 8'h99;
                byte_count  = 15'd5;
                delay_ticks = 8'd0;
            end else if (inject && i == 5) begin
                start = 1'b0;
            end
            if (done_cnt > 0 && !busy && !(inject && i < 6)) begin
                finished = 1'b1;
                break;
            end
        end
        checkOutput({name, "_finished"}, 32'(finished), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_xfers"}, xfer_log.size(), cnt);
        for (int k = 0; k < xfer_log.size() && k < cnt; k++)
            checkOutput({name, "_byte"}, xfer_log[k], (32'(d) + k) % 256);
        checkOutput({name, "_gaps"}, gap_log.size(), (cnt > 0) ? cnt - 1 : 0);
        foreach (gap_log[k]) checkOutput({name, "_gap_ticks"}, gap_log[k], dly);
        checkOutput({name, "_done_cnt"}, done_cnt, 32'd1);
        checkOutput({name, "_bytes_sent"}, 32'(bytes_sent), cnt);
        checkOutput({name, "_busy_end"}, 32'(busy), 32'd0);
        checkOutput({name, "_stable"}, stall_err, 32'd0);
        if (cnt > 0) checkOutput({name, "_done_latency"}, first_done_cycle - last_xfer_cycle, 32'd1);
        else begin
            checkOutput({name, "_busy_seen"}, 32'(busy_seen), 32'd0);
            checkOutput({name, "_valid_seen"}, 32'(valid_seen), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        $display("[TB] uart_tx_sequencer bench start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("rst_data", 32'(tx_if.tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sent", 32'(bytes_sent), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        ready_mode = 0; tick_period = 1;
        runSequence(8'h41, 3, 0, 1'b0, "b2b");

        ready_mode = 2; tick_period = 4;
        runSequence(8'hFE, 3, 2, 1'b0, "gap_wrap");

        ready_mode = 0; tick_period = 1;
        runSequence(8'h5A, 0, 1, 1'b0, "zero");

        ready_mode = 1; tick_period = 0;
        runSequence(8'h10, 10, 1, 1'b1, "start_busy");

        for (int r = 0; r < 8; r++) begin
            ready_mode  = $urandom_range(0, 2);
            tick_period = $urandom_range(0, 3);
            runSequence(DATA_W'($urandom), $urandom_range(0, 12), $urandom_range(0, 3), 1'b0, "rand");
        end

        // Asynchronous reset in the middle of a running sequence
        ready_mode = 0; tick_period = 1;
        applyStimulus(8'h20, 20, 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_if.tx_valid) begin seen = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        checkOutput("mid_valid_before", 32'(seen), 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(tx_if.tx_data), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_sent", 32'(bytes_sent), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        resetStats();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_rst_done_cnt", done_cnt, 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_valid_seen", 32'(valid_seen), 32'd0);

`ifdef UART_TX_SEQ_ABORT_EN
        // Abort coinciding with the 5th transfer of a 256-byte back-to-back run
        begin
            bit fired = 1'b0;
            logic [DATA_W-1:0] d0 = DATA_W'($urandom);
            applyStimulus(d0, 256, 0);
            for (int i = 0; i < 100; i++) begin
                if (abort) begin
                    abort = 1'b0;
                    fired = 1'b1;
                    break;
                end
                if (tx_if.tx_valid && bytes_sent == 15'd4) abort = 1'b1;
                @(posedge clk);
                #1;
            end
            checkOutput("abort_fired", 32'(fired), 32'd1);
            checkOutput("abort_valid", 32'(tx_if.tx_valid), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_pulse", 32'(aborted), 32'd1);
            checkOutput("abort_sent", 32'(bytes_sent), 32'd5);
            repeat (3) @(posedge clk);
            #1;
            checkOutput("abort_cnt", aborted_cnt, 32'd1);
            checkOutput("abort_no_done", done_cnt, 32'd0);
            checkOutput("abort_xfers", xfer_log.size(), 32'd5);
            for (int k = 0; k < xfer_log.size() && k < 5; k++)
                checkOutput("abort_byte", xfer_log[k], (32'(d0) + k) % 256);
            // Abort while idle must do nothing
            resetStats();
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checkOutput("abort_idle_pulse", aborted_cnt, 32'd0);
            checkOutput("abort_idle_sent", 32'(bytes_sent), 32'd5);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
